// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / branch-control stage.
//   - pc_state_t : control FSM states (IDLE, RUN, HALT)
//   - PC_W_DEF   : default program counter width
//   - LUT_AW_DEF : default branch-target LUT index width
//   - pc_word_t  : PC word at the default width
package pc_pkg;

    localparam int PC_W_DEF   = 10;
    localparam int LUT_AW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    typedef logic [PC_W_DEF-1:0] pc_word_t;

endpackage

// File: rtl/branch_lut.sv
// Branch/jump target lookup table: 2^LUT_AW entries of PC_W bits.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low clear of every entry
//   we, waddr, wdata - synchronous write port
//   raddr, rdata     - combinational read port (returns the pre-write entry
//                      when a write to the same index is pending this cycle)
module branch_lut
    import pc_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [PC_W-1:0]   wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [PC_W-1:0]   rdata
);

    localparam int DEPTH = 1 << LUT_AW;

    logic [PC_W-1:0] mem_r [DEPTH];

    // Entry storage: cleared on reset, written on enabled clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {PC_W{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Combinational read port.
    always_comb begin
        rdata = mem_r[raddr];
    end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Program counter and branch control following the ALU.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - begin execution at PC 0 (from IDLE or HALT)
//   stall        - hold PC, flag and state for this cycle
//   alu_flag     - ALU jump flag; flag_we loads it into flag_q
//   branch_en    - branch to LUT[tgt_idx] when flag_q is set
//   jump_en      - unconditional jump to LUT[tgt_idx]
//   halt         - stop execution, PC holds
//   tgt_idx      - target LUT index
//   lut_we/lut_waddr/lut_wdata - target LUT write port (any state)
//   pc           - instruction fetch address
//   fetch_valid  - high while running
//   flag_q       - registered ALU flag
//   done         - high while halted
module branch_pc_ctrl
    import pc_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              alu_flag,
    input  logic              flag_we,
    input  logic              branch_en,
    input  logic              jump_en,
    input  logic              halt,
    input  logic [LUT_AW-1:0] tgt_idx,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              fetch_valid,
    output logic              flag_q,
    output logic              done
);

    localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};

    pc_state_t       state_r;
    pc_state_t       state_nxt_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic            flag_r;
    logic            flag_nxt_s;
    logic [PC_W-1:0] tgt_pc_s;

    branch_lut #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (tgt_idx),
        .rdata (tgt_pc_s)
    );

    // State, PC and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= {PC_W{1'b0}};
            flag_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            flag_r  <= flag_nxt_s;
        end
    end

    // Next-state, next-PC and next-flag decode.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        flag_nxt_s  = flag_r;
        case (state_r)
            ST_IDLE: begin
                pc_nxt_s = {PC_W{1'b0}};
                if (start) begin
                    state_nxt_s = ST_RUN;
                    flag_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stall) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    // Branch below reads flag_r, so a same-cycle load only
                    // affects the following instruction.
                    if (flag_we) begin
                        flag_nxt_s = alu_flag;
                    end else begin
                        flag_nxt_s = flag_r;
                    end
                    if (halt) begin
                        state_nxt_s = ST_HALT;
                    end else if (jump_en) begin
                        pc_nxt_s = tgt_pc_s;
                    end else if (branch_en && flag_r) begin
                        pc_nxt_s = tgt_pc_s;
                    end else if (pc_r == PC_MAX) begin
                        // Runaway guard: never wrap past the top address.
                        state_nxt_s = ST_HALT;
                    end else begin
                        pc_nxt_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = {PC_W{1'b0}};
                    flag_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = {PC_W{1'b0}};
                flag_nxt_s  = 1'b0;
            end
        endcase
    end

    // Outputs are the registers themselves or pure state decodes.
    always_comb begin
        pc          = pc_r;
        flag_q      = flag_r;
        fetch_valid = (state_r == ST_RUN);
        done        = (state_r == ST_HALT);
    end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed self-checking bench for branch_pc_ctrl.
module tb_branch_pc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stall;
    logic       alu_flag;
    logic       flag_we;
    logic       branch_en;
    logic       jump_en;
    logic       halt;
    logic [3:0] tgt_idx;
    logic       lut_we;
    logic [3:0] lut_waddr;
    logic [9:0] lut_wdata;
    logic [9:0] pc;
    logic       fetch_valid;
    logic       flag_q;
    logic       done;

    int checks   = 0;
    int failures = 0;

    branch_pc_ctrl #(.PC_W(10), .LUT_AW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .alu_flag    (alu_flag),
        .flag_we     (flag_we),
        .branch_en   (branch_en),
        .jump_en     (jump_en),
        .halt        (halt),
        .tgt_idx     (tgt_idx),
        .lut_we      (lut_we),
        .lut_waddr   (lut_waddr),
        .lut_wdata   (lut_wdata),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .flag_q      (flag_q),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [9:0] e_pc, input logic e_fv,
                              input logic e_flag, input logic e_done);
        check({tag, ".pc"},   {22'd0, pc},          {22'd0, e_pc});
        check({tag, ".fv"},   {31'd0, fetch_valid}, {31'd0, e_fv});
        check({tag, ".flag"}, {31'd0, flag_q},      {31'd0, e_flag});
        check({tag, ".done"}, {31'd0, done},        {31'd0, e_done});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; alu_flag = 1'b0; flag_we = 1'b0;
        branch_en = 1'b0; jump_en = 1'b0; halt = 1'b0; tgt_idx = 4'd0;
        lut_we = 1'b0; lut_waddr = 4'd0; lut_wdata = 10'd0;
        #12;
        check_outs("reset", 10'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_outs("idle", 10'd0, 1'b0, 1'b0, 1'b0);

        // Increment and halt
        start = 1'b1; step(); start = 1'b0;
        check_outs("start", 10'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("inc.pc", {22'd0, pc}, i);
        end
        halt = 1'b1; step(); halt = 1'b0;
        check_outs("halt", 10'd4, 1'b0, 1'b0, 1'b1);
        step();
        check_outs("halt_hold", 10'd4, 1'b0, 1'b0, 1'b1);

        // Conditional branch with same-cycle flag write
        lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'h120;
        start = 1'b1; step(); start = 1'b0; lut_we = 1'b0;
        check_outs("restart", 10'd0, 1'b1, 1'b0, 1'b0);
        step(); step();
        check("pc2", {22'd0, pc}, 32'd2);
        flag_we = 1'b1; alu_flag = 1'b1; branch_en = 1'b1; tgt_idx = 4'd3;
        step(); flag_we = 1'b0; alu_flag = 1'b0;
        check_outs("br_oldflag", 10'd3, 1'b1, 1'b1, 1'b0);
        step(); branch_en = 1'b0;
        check_outs("br_taken", 10'h120, 1'b1, 1'b1, 1'b0);

        // Stall holds everything, including a pending flag load
        stall = 1'b1; jump_en = 1'b1; flag_we = 1'b1; alu_flag = 1'b0; halt = 1'b1;
        step(); stall = 1'b0; flag_we = 1'b0; halt = 1'b0;
        check_outs("stall", 10'h120, 1'b1, 1'b1, 1'b0);
        // Halt beats jump
        halt = 1'b1; step(); halt = 1'b0; jump_en = 1'b0;
        check_outs("halt_prio", 10'h120, 1'b0, 1'b1, 1'b1);

        // LUT write/read same cycle returns the old entry
        start = 1'b1; step(); start = 1'b0;
        check_outs("restart2", 10'd0, 1'b1, 1'b0, 1'b0);
        lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 10'h3FF; jump_en = 1'b1; tgt_idx = 4'd5;
        step(); lut_we = 1'b0;
        check("lut_old", {22'd0, pc}, 32'd0);
        step(); jump_en = 1'b0;
        check("lut_new", {22'd0, pc}, 32'h3FF);

        // Runaway guard
        step();
        check_outs("runaway", 10'h3FF, 1'b0, 1'b0, 1'b1);
        step();
        check("runaway_hold", {22'd0, pc}, 32'h3FF);
        start = 1'b1; step(); start = 1'b0;
        check_outs("restart3", 10'd0, 1'b1, 1'b0, 1'b0);

        // Set the flag, then reset asynchronously mid-RUN
        flag_we = 1'b1; alu_flag = 1'b1; step(); flag_we = 1'b0; alu_flag = 1'b0;
        check_outs("preflag", 10'd1, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 10'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_outs("post_rst_idle", 10'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        jump_en = 1'b1; tgt_idx = 4'd5; step();
        check("lut5_cleared", {22'd0, pc}, 32'd0);
        tgt_idx = 4'd3; step(); jump_en = 1'b0;
        check("lut3_cleared", {22'd0, pc}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
